// File: rtl/iterative_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_shift_unit
//  Description : Multi-cycle shift/rotate engine. Moves the operand one bit
//                per clock (SHL, SHR, SHRA, ROL, ROR) and holds the result on
//                data_out once done pulses. Sequential twin of the
//                combinational shifter: same results, fewer gates.
//  Revision    : 1.0 - initial release
// ============================================================================
module iterative_shift_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      shift_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    localparam logic [31:0] WIDTH_32 = 32'(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_step;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_n_load;

    // Effective iteration count: shifts saturate at WIDTH, rotates wrap
    // modulo WIDTH, illegal ops take zero steps so the operand passes through.
    always_comb begin
        w_n_load = '0;
        case (op)
            OP_SHL, OP_SHR, OP_SHRA:
                w_n_load = CNT_W'((shift_val > WIDTH_32) ? WIDTH_32 : shift_val);
            OP_ROL, OP_ROR:
                w_n_load = CNT_W'(shift_val % WIDTH_32);
            default:
                w_n_load = '0;
        endcase
    end

    // One-bit move of the work register for the latched operation.
    always_comb begin
        w_work_step = r_work;
        case (r_op)
            OP_SHL:  w_work_step = {r_work[WIDTH-2:0], 1'b0};
            OP_SHR:  w_work_step = {1'b0, r_work[WIDTH-1:1]};
            OP_SHRA: w_work_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            OP_ROL:  w_work_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            OP_ROR:  w_work_step = {r_work[0], r_work[WIDTH-1:1]};
            default: w_work_step = r_work;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN exits only once the counter has drained.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (r_count == '0) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded purely from the registered state.
    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    // Datapath: capture on accept, step while counting, publish on drain.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_work   <= '0;
            r_op     <= '0;
            r_count  <= '0;
            data_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work  <= data_in;
                        r_op    <= op;
                        r_count <= w_n_load;
                    end
                end
                ST_RUN: begin
                    if (r_count != '0) begin
                        r_work  <= w_work_step;
                        r_count <= r_count - CNT_W'(1);
                    end else begin
                        data_out <= r_work;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iterative_shift_unit
//  Description : Self-checking bench for iterative_shift_unit. A transaction
//                level model predicts busy/done/data_out every cycle; directed
//                cases carry hand-computed results and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_shift_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [31:0] shift_val;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    iterative_shift_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .op        (op),
        .data_in   (data_in),
        .shift_val (shift_val),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the language operators.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] d,
                                               input logic [31:0] sv);
        logic [63:0] dd;
        int          k;
        dd = {d, d};
        k  = int'(sv % 32);
        case (o)
            3'd0: return (sv >= 32) ? 32'd0 : (d << sv);
            3'd1: return (sv >= 32) ? 32'd0 : (d >> sv);
            3'd2: return (sv >= 32) ? {32{d[31]}} : 32'($signed(d) >>> sv);
            3'd3: begin dd = dd << k; return dd[63:32]; end
            3'd4: begin dd = dd >> k; return dd[31:0]; end
            default: return d;
        endcase
    endfunction

    function automatic int n_of(input logic [2:0] o, input logic [31:0] sv);
        if (o <= 3'd2) return (sv > 32) ? 32 : int'(sv);
        if (o <= 3'd4) return int'(sv % 32);
        return 0;
    endfunction

    // Transaction model: an accepted request finishes N+1 edges later,
    // after which the unit stays busy for one more (DONE) cycle.
    int          cyc = 0;
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          m_done_edge = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_out = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!clear) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_out    <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active    <= 1'b1;
                    m_done_edge <= cyc + n_of(op, shift_val) + 1;
                    m_res       <= ref_result(op, data_in, shift_val);
                end
            end else if (cyc == m_done_edge) begin
                m_out  <= m_res;
                m_done <= 1'b1;
            end else if (cyc == m_done_edge + 1) begin
                m_active <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_active});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("data_out", data_out, m_out);
        end
    end

    // Issue one request from an idle negedge; finish on the negedge where busy drops.
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] sv,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        int done_lat;
        int busy_cnt;
        int done_cnt;
        lat = 0; done_lat = 0; busy_cnt = 0; done_cnt = 0;
        start = 1'b1; op = o; data_in = d; shift_val = sv;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            start     = 1'b0;
            data_in   = ~d;
            shift_val = sv + 32'd3;
            op        = o ^ 3'b001;
            lat++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_lat = lat;
                    check({name, " result"}, data_out, exp_res);
                end
            end
            if (!busy) break;
        end
        check({name, " done_count"}, done_cnt, 1);
        check({name, " latency"}, done_lat, exp_lat);
        check({name, " busy_cycles"}, busy_cnt, exp_lat);
        check({name, " held"}, data_out, exp_res);
    endtask

    initial begin
        int          done_cnt;
        int          lat;
        logic [2:0]  ro;
        logic [31:0] rd;
        logic [31:0] rs;

        clear = 1'b0; start = 1'b0; op = '0; data_in = '0; shift_val = '0;
        repeat (3) @(negedge clock);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset data_out", data_out, 32'd0);
        clear  = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);

        run_op(3'b000, 32'h0000_00F1, 32'd4,   32'h0000_0F10, 6,  "shl");
        run_op(3'b010, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 34, "shra_sat");
        run_op(3'b001, 32'h8000_0000, 32'd100, 32'h0000_0000, 34, "shr_sat");
        run_op(3'b100, 32'h0000_0001, 32'd33,  32'h8000_0000, 3,  "ror_mod");
        run_op(3'b011, 32'h0000_0001, 32'd32,  32'h0000_0001, 2,  "rol_zero");
        run_op(3'b110, 32'hDEAD_BEEF, 32'd7,   32'hDEAD_BEEF, 2,  "illegal");
        run_op(3'b010, 32'h4000_0000, 32'd32,  32'h0000_0000, 34, "shra_pos_sat");

        // Start pulse mid-RUN must be ignored.
        start = 1'b1; op = 3'b011; data_in = 32'h1234_5678; shift_val = 32'd8;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1; op = 3'b001; data_in = 32'hFFFF_FFFF; shift_val = 32'd0;
        @(negedge clock);
        start = 1'b0;
        done_cnt = 0; lat = 5;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                done_cnt++;
                check("ignore latency", lat, 10);
                check("ignore result", data_out, 32'h3456_7812);
            end
            if (!busy) break;
            @(negedge clock);
            lat++;
        end
        check("ignore done_count", done_cnt, 1);
        check("ignore idle", {31'd0, busy}, 32'd0);
        run_op(3'b000, 32'h0000_0001, 32'd1, 32'h0000_0002, 3, "back_to_back");

        // Reset in the middle of a long SHL.
        start = 1'b1; op = 3'b000; data_in = 32'h0000_0001; shift_val = 32'd20;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        clear = 1'b0;
        repeat (2) @(negedge clock);
        clear = 1'b1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset data_out", data_out, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("midreset no_done", done_cnt, 0);

        for (int t = 0; t < 2000; t++) begin
            ro = 3'($urandom_range(0, 4));
            rd = $urandom;
            rs = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            run_op(ro, rd, rs, ref_result(ro, rd, rs), n_of(ro, rs) + 2, "random");
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
